loop_osc_monitor: RTL
=====================

LOOP_OSC_MONITOR -- requirements
Module: loop_osc_monitor

Interface
REQ-001 Parameter NUM_LOOPS, default 3, number of independent broken-loop channels (1..16).
REQ-002 Parameter CNT_W, default 8, toggle-counter width per channel.
REQ-003 Parameter THRESH, default 16, toggle count that declares oscillation (1..2^CNT_W-1).
REQ-004 Parameter QUIET, default 4, consecutive no-change cycles that declare a stable loop (>=1).
REQ-005 Parameter INIT_VAL, default all-zero NUM_LOOPS bits, breaker register value in IDLE.
REQ-006 clk  in  1  single clock, all state on rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 enable  in  NUM_LOOPS  per-channel arm request, level-sensitive.
REQ-009 clear  in  NUM_LOOPS  per-channel return-to-IDLE request, single-cycle pulse.
REQ-010 fb_in  in  NUM_LOOPS  loop return value computed externally from breaker_q.
REQ-011 breaker_q  out  NUM_LOOPS  registered loop-breaker value driven into the external loop.
REQ-012 osc_flag  out  NUM_LOOPS  sticky: channel declared oscillating.
REQ-013 stable_flag  out  NUM_LOOPS  sticky: channel declared settled.
REQ-014 any_osc  out  1  OR of osc_flag.
REQ-015 first_osc_id  out  4  index of lowest channel with osc_flag set; 0 when none.
REQ-016 irq  out  1  one-cycle pulse on any channel's transition into OSC.

Function
REQ-017 Per-channel FSM states: IDLE, TRACK, OSC, STABLE.
REQ-018 IDLE: breaker_q = INIT_VAL bit, counters 0; enable=1 -> TRACK next cycle.
REQ-019 TRACK: breaker_q <= fb_in every cycle; toggle when fb_in != breaker_q.
REQ-020 TRACK: toggle increments tog_cnt, saturates at 2^CNT_W-1, resets quiet_cnt to 0; no toggle increments quiet_cnt.
REQ-021 TRACK -> OSC in the cycle tog_cnt reaches THRESH (counting the current toggle); osc_flag rises on the same edge.
REQ-022 TRACK -> STABLE when quiet_cnt reaches QUIET; stable_flag rises on the same edge.
REQ-023 Simultaneous THRESH and QUIET conditions are impossible by construction; if both evaluate true, OSC wins.
REQ-024 OSC: breaker_q frozen at last captured value (loop held broken); fb_in ignored.
REQ-025 STABLE: breaker_q keeps tracking fb_in; any toggle -> TRACK with quiet_cnt=0, tog_cnt retained, stable_flag cleared.
REQ-026 enable=0 in TRACK -> IDLE; in OSC/STABLE enable has no effect.
REQ-027 clear has priority over enable and all FSM transitions: next state IDLE, flags and counters 0, breaker_q = INIT_VAL.
REQ-028 irq = 1 for exactly one cycle when at least one channel enters OSC that cycle; multiple simultaneous entries give one pulse.
REQ-029 first_osc_id and any_osc are combinational from registered osc_flag (zero added latency).

Reset
REQ-030 rst=1 on a clock edge: all channels IDLE, breaker_q = INIT_VAL, osc_flag = stable_flag = 0, counters 0, irq = 0.
REQ-031 rst mid-TRACK or mid-OSC yields the same state as REQ-030; rst overrides clear and enable.

Structure
REQ-032 Shared package loop_osc_pkg holds the state enum (IDLE, TRACK, OSC, STABLE) and the channel-index width constant (4).
REQ-033 One sub-module loop_osc_chan implements a single channel (FSM, counters, breaker flop); top instantiates NUM_LOOPS copies plus the priority encoder and irq logic.

Verification
REQ-034 Inverting loop: fb_in = ~breaker_q on ch0, THRESH=16, enable at cycle 0 -> osc_flag[0]=1 and irq pulse at cycle 17, breaker_q[0] frozen afterward.
REQ-035 Non-inverting loop: fb_in = breaker_q on ch1, QUIET=4 -> stable_flag[1]=1 at cycle 5, osc_flag[1]=0.
REQ-036 ch2 and ch1 both oscillate and reach THRESH in the same cycle -> single irq pulse, first_osc_id=1, any_osc=1.
REQ-037 clear[0] asserted in OSC with enable[0]=1 held -> IDLE next edge, osc_flag[0]=0, breaker_q[0]=INIT_VAL bit, TRACK one cycle later.
REQ-038 rst asserted after 10 toggles in TRACK -> all outputs at reset values next edge; re-enable requires full 16 toggles again.
REQ-039 Stable channel then one fb_in flip -> stable_flag cleared, state TRACK; CNT_W=4, THRESH=15 saturation check at 15.

Source files
------------

// File: rtl/loop_osc_pkg.sv
// Shared definitions for the broken-loop oscillation monitor.
//   chan_state_e : per-channel FSM state encoding
//   ChanIdW      : width of a channel index (up to 16 channels)
package loop_osc_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StTrack,
    StOsc,
    StStable
  } chan_state_e;

  localparam int unsigned ChanIdW = 4;

endpackage

// File: rtl/loop_osc_chan.sv
// One broken-loop channel: breaker flop, toggle/quiet counters and state FSM.
// The breaker register cuts an external combinational loop; each cycle the channel
// compares the loop's return value against what it drove and counts changes.
// Ports:
//   clk_i, rst_i    clock, synchronous active-high reset
//   enable_i        arm request (level)
//   clear_i         return-to-idle pulse, overrides everything except reset
//   fb_i            loop return value
//   breaker_o       registered value driven into the loop
//   osc_flag_o      sticky oscillation flag
//   stable_flag_o   sticky settled flag
//   osc_enter_o     combinational: channel enters OSC on the coming edge
module loop_osc_chan
  import loop_osc_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned THRESH   = 16,
  parameter int unsigned QUIET    = 4,
  parameter bit          INIT_BIT = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic clear_i,
  input  logic fb_i,
  output logic breaker_o,
  output logic osc_flag_o,
  output logic stable_flag_o,
  output logic osc_enter_o
);

  localparam int unsigned       QuietW    = $clog2(QUIET + 1);
  localparam logic [CNT_W-1:0]  ThreshVal = CNT_W'(THRESH);
  localparam logic [QuietW-1:0] QuietVal  = QuietW'(QUIET);

  chan_state_e       state_q, state_d;
  logic              breaker_q, breaker_d;
  logic [CNT_W-1:0]  tog_cnt_q, tog_cnt_d;
  logic [QuietW-1:0] quiet_cnt_q, quiet_cnt_d;
  logic              osc_q, osc_d;
  logic              stable_q, stable_d;

  logic              toggle;
  logic [CNT_W-1:0]  tog_inc;
  logic [QuietW-1:0] quiet_inc;

  assign toggle    = (fb_i != breaker_q);
  // Saturating toggle count; the quiet count never passes QUIET because the
  // channel leaves TRACK when it gets there.
  assign tog_inc   = (tog_cnt_q == {CNT_W{1'b1}}) ? tog_cnt_q : tog_cnt_q + CNT_W'(1);
  assign quiet_inc = quiet_cnt_q + QuietW'(1);

  always_comb begin
    state_d     = state_q;
    breaker_d   = breaker_q;
    tog_cnt_d   = tog_cnt_q;
    quiet_cnt_d = quiet_cnt_q;
    osc_d       = osc_q;
    stable_d    = stable_q;
    osc_enter_o = 1'b0;

    if (clear_i) begin
      state_d     = StIdle;
      breaker_d   = INIT_BIT;
      tog_cnt_d   = '0;
      quiet_cnt_d = '0;
      osc_d       = 1'b0;
      stable_d    = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          breaker_d   = INIT_BIT;
          tog_cnt_d   = '0;
          quiet_cnt_d = '0;
          osc_d       = 1'b0;
          stable_d    = 1'b0;
          if (enable_i) state_d = StTrack;
        end
        StTrack: begin
          if (!enable_i) begin
            state_d     = StIdle;
            breaker_d   = INIT_BIT;
            tog_cnt_d   = '0;
            quiet_cnt_d = '0;
          end else begin
            breaker_d = fb_i;
            if (toggle) begin
              tog_cnt_d   = tog_inc;
              quiet_cnt_d = '0;
              // Threshold counts the toggle seen this cycle.
              if (tog_inc >= ThreshVal) begin
                state_d     = StOsc;
                osc_d       = 1'b1;
                osc_enter_o = 1'b1;
              end
            end else begin
              quiet_cnt_d = quiet_inc;
              if (quiet_inc >= QuietVal) begin
                state_d  = StStable;
                stable_d = 1'b1;
              end
            end
          end
        end
        StOsc: begin
          // Loop held broken: breaker frozen, feedback ignored.
        end
        StStable: begin
          breaker_d = fb_i;
          if (toggle) begin
            state_d     = StTrack;
            quiet_cnt_d = '0;
            stable_d    = 1'b0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      breaker_q   <= INIT_BIT;
      tog_cnt_q   <= '0;
      quiet_cnt_q <= '0;
      osc_q       <= 1'b0;
      stable_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      breaker_q   <= breaker_d;
      tog_cnt_q   <= tog_cnt_d;
      quiet_cnt_q <= quiet_cnt_d;
      osc_q       <= osc_d;
      stable_q    <= stable_d;
    end
  end

  assign breaker_o     = breaker_q;
  assign osc_flag_o    = osc_q;
  assign stable_flag_o = stable_q;

endmodule

// File: rtl/loop_osc_monitor.sv
// Multi-channel broken-loop oscillation monitor.
// Each channel breaks an external loop with a register and classifies the loop as
// oscillating (too many toggles) or stable (enough quiet cycles).
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   enable         per-channel arm request (level)
//   clear          per-channel return-to-idle pulse
//   fb_in          per-channel loop return value
//   breaker_q      per-channel registered breaker value
//   osc_flag       per-channel sticky oscillation flag
//   stable_flag    per-channel sticky settled flag
//   any_osc        OR of osc_flag
//   first_osc_id   lowest channel index with osc_flag set, 0 when none
//   irq            one-cycle pulse when any channel enters OSC
module loop_osc_monitor
  import loop_osc_pkg::*;
#(
  parameter int unsigned          NUM_LOOPS = 3,
  parameter int unsigned          CNT_W     = 8,
  parameter int unsigned          THRESH    = 16,
  parameter int unsigned          QUIET     = 4,
  parameter logic [NUM_LOOPS-1:0] INIT_VAL  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LOOPS-1:0] enable,
  input  logic [NUM_LOOPS-1:0] clear,
  input  logic [NUM_LOOPS-1:0] fb_in,
  output logic [NUM_LOOPS-1:0] breaker_q,
  output logic [NUM_LOOPS-1:0] osc_flag,
  output logic [NUM_LOOPS-1:0] stable_flag,
  output logic                 any_osc,
  output logic [ChanIdW-1:0]   first_osc_id,
  output logic                 irq
);

  logic [NUM_LOOPS-1:0] osc_enter;
  logic                 irq_q, irq_d;

  for (genvar g = 0; g < NUM_LOOPS; g++) begin : g_chan
    loop_osc_chan #(
      .CNT_W    (CNT_W),
      .THRESH   (THRESH),
      .QUIET    (QUIET),
      .INIT_BIT (INIT_VAL[g])
    ) u_chan (
      .clk_i         (clk),
      .rst_i         (rst),
      .enable_i      (enable[g]),
      .clear_i       (clear[g]),
      .fb_i          (fb_in[g]),
      .breaker_o     (breaker_q[g]),
      .osc_flag_o    (osc_flag[g]),
      .stable_flag_o (stable_flag[g]),
      .osc_enter_o   (osc_enter[g])
    );
  end

  // Registered so the pulse lines up with the osc_flag it announces.
  assign irq_d = |osc_enter;

  always_ff @(posedge clk) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_d;
  end

  assign irq     = irq_q;
  assign any_osc = |osc_flag;

  // Scan from the top so the lowest set index wins.
  always_comb begin
    first_osc_id = '0;
    for (int i = int'(NUM_LOOPS) - 1; i >= 0; i--) begin
      if (osc_flag[i]) first_osc_id = ChanIdW'(i);
    end
  end

endmodule
